// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile datapath: bank geometry, the one-hot
// write-enable type and its legality classifier.
package regfile_pkg;

   localparam int NUM_REGS = 4;
   localparam int ADDR_W   = 2;

   typedef logic [NUM_REGS-1:0] onehot_t;

   typedef enum logic [1:0] {
      WR_NONE  = 2'd0,
      WR_LEGAL = 2'd1,
      WR_MULTI = 2'd2
   } wr_class_e;

   typedef struct packed {
      logic exactly_one;
      logic multi_hot;
   } onehot_class_t;

   function automatic onehot_class_t onehot_legal(input onehot_t vec);
      onehot_class_t res;
      logic [2:0]    cnt;
      cnt = 3'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt = cnt + {2'b00, vec[i]};
      end
      res.exactly_one = (cnt == 3'd1);
      res.multi_hot   = (cnt > 3'd1);
      return res;
   endfunction

endpackage

// File: rtl/regbank_onehot_guard.sv
// Classifies the decoder's one-hot write enable and turns it into qualified
// per-register write strobes; illegal multi-hot enables write nothing.
module regbank_onehot_guard
   import regfile_pkg::*;
#(
   parameter int ZERO_REG0 = 1
) (
   input  logic [NUM_REGS-1:0] wr_onehot,
   output logic [NUM_REGS-1:0] wr_strobe,
   output wr_class_e           wr_class
);

   onehot_class_t cls_s;

   // Classify the enable vector into none / legal / multi-hot
   always_comb begin
      cls_s = onehot_legal(wr_onehot);
      case ({cls_s.exactly_one, cls_s.multi_hot})
         2'b00:   wr_class = WR_NONE;
         2'b10:   wr_class = WR_LEGAL;
         2'b01:   wr_class = WR_MULTI;
         default: wr_class = WR_MULTI;
      endcase
   end

   // Qualified strobes; register 0 is never strobed when it is the zero register
   always_comb begin
      wr_strobe = {NUM_REGS{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wr_class == WR_LEGAL && wr_onehot[i] && !(i == 0 && ZERO_REG0 != 0)) begin
            wr_strobe[i] = 1'b1;
         end else begin
            wr_strobe[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/regbank4_onehot_wr.sv
// Four-entry register bank with one-hot write enable, two registered read
// ports with same-edge write forwarding, sticky written[] and wr_error flags.
module regbank4_onehot_wr
   import regfile_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int ZERO_REG0 = 1
) (
   input  logic                clock,
   input  logic                ctrl_reset_n,
   input  logic [NUM_REGS-1:0] wr_onehot,
   input  logic [WIDTH-1:0]    data_writeReg,
   input  logic [ADDR_W-1:0]   ctrl_readRegA,
   input  logic [ADDR_W-1:0]   ctrl_readRegB,
   input  logic                rd_req,
   input  logic                clr_written,
   output logic [WIDTH-1:0]    data_readRegA,
   output logic [WIDTH-1:0]    data_readRegB,
   output logic                rd_valid,
   output logic [NUM_REGS-1:0] written,
   output logic                wr_error
);

   logic [WIDTH-1:0]    regs_r     [NUM_REGS];
   logic [WIDTH-1:0]    reg_next_s [NUM_REGS];
   logic [NUM_REGS-1:0] wr_strobe_s;
   wr_class_e           wr_class_s;
   logic                multi_hot_s;
   logic [WIDTH-1:0]    rd_a_s;
   logic [WIDTH-1:0]    rd_b_s;
   logic [WIDTH-1:0]    rd_a_r;
   logic [WIDTH-1:0]    rd_b_r;
   logic                rd_valid_r;
   logic [NUM_REGS-1:0] written_r;
   logic                wr_error_r;

   regbank_onehot_guard #(
      .ZERO_REG0 (ZERO_REG0)
   ) u_guard (
      .wr_onehot (wr_onehot),
      .wr_strobe (wr_strobe_s),
      .wr_class  (wr_class_s)
   );

   assign multi_hot_s = (wr_class_s == WR_MULTI);

   // Post-write view of every register; this is what makes same-edge forwarding work
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wr_strobe_s[i]) begin
            reg_next_s[i] = data_writeReg;
         end else begin
            reg_next_s[i] = regs_r[i];
         end
      end
   end

   // Read-port muxes over the post-write view, zero register forced to 0
   always_comb begin
      if (ZERO_REG0 != 0 && ctrl_readRegA == 2'd0) begin
         rd_a_s = {WIDTH{1'b0}};
      end else begin
         rd_a_s = reg_next_s[ctrl_readRegA];
      end
      if (ZERO_REG0 != 0 && ctrl_readRegB == 2'd0) begin
         rd_b_s = {WIDTH{1'b0}};
      end else begin
         rd_b_s = reg_next_s[ctrl_readRegB];
      end
   end

   // Register array, read outputs and sticky status, reset overriding everything
   always_ff @(posedge clock) begin
      if (!ctrl_reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {WIDTH{1'b0}};
         end
         rd_a_r     <= {WIDTH{1'b0}};
         rd_b_r     <= {WIDTH{1'b0}};
         rd_valid_r <= 1'b0;
         written_r  <= {NUM_REGS{1'b0}};
         wr_error_r <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= reg_next_s[i];
         end
         // A legal write's set bit wins over a same-edge clear
         if (clr_written) begin
            written_r <= wr_strobe_s;
         end else begin
            written_r <= written_r | wr_strobe_s;
         end
         wr_error_r <= wr_error_r | multi_hot_s;
         rd_valid_r <= rd_req;
         if (rd_req) begin
            rd_a_r <= rd_a_s;
            rd_b_r <= rd_b_s;
         end else begin
            rd_a_r <= rd_a_r;
            rd_b_r <= rd_b_r;
         end
      end
   end

   assign data_readRegA = rd_a_r;
   assign data_readRegB = rd_b_r;
   assign rd_valid      = rd_valid_r;
   assign written       = written_r;
   assign wr_error      = wr_error_r;

endmodule

// File: tb/tb_regbank4_onehot_wr.sv
// Randomised self-checking bench for regbank4_onehot_wr against a
// behavioural model of the register bank.
module tb_regbank4_onehot_wr;

   localparam int WIDTH     = 32;
   localparam int ZERO_REG0 = 1;

   logic              clock;
   logic              ctrl_reset_n;
   logic [3:0]        wr_onehot;
   logic [WIDTH-1:0]  data_writeReg;
   logic [1:0]        ctrl_readRegA;
   logic [1:0]        ctrl_readRegB;
   logic              rd_req;
   logic              clr_written;
   logic [WIDTH-1:0]  data_readRegA;
   logic [WIDTH-1:0]  data_readRegB;
   logic              rd_valid;
   logic [3:0]        written;
   logic              wr_error;

   int checks_cnt;
   int fail_cnt;

   logic [WIDTH-1:0] m_reg [4];
   logic [WIDTH-1:0] m_a;
   logic [WIDTH-1:0] m_b;
   logic             m_v;
   logic [3:0]       m_wr;
   logic             m_err;

   regbank4_onehot_wr #(
      .WIDTH     (WIDTH),
      .ZERO_REG0 (ZERO_REG0)
   ) dut (
      .clock         (clock),
      .ctrl_reset_n  (ctrl_reset_n),
      .wr_onehot     (wr_onehot),
      .data_writeReg (data_writeReg),
      .ctrl_readRegA (ctrl_readRegA),
      .ctrl_readRegB (ctrl_readRegB),
      .rd_req        (rd_req),
      .clr_written   (clr_written),
      .data_readRegA (data_readRegA),
      .data_readRegB (data_readRegB),
      .rd_valid      (rd_valid),
      .written       (written),
      .wr_error      (wr_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Reference model: apply the edge's rules to the abstract register state
   task automatic model_edge();
      int n;
      n = $countones(wr_onehot);
      if (!ctrl_reset_n) begin
         for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
         m_a = 32'h0; m_b = 32'h0; m_v = 1'b0; m_wr = 4'h0; m_err = 1'b0;
      end else begin
         if (clr_written) m_wr = 4'h0;
         if (n == 1) begin
            for (int i = 0; i < 4; i++) begin
               if (wr_onehot[i] && !(i == 0 && ZERO_REG0 != 0)) begin
                  m_reg[i] = data_writeReg;
                  m_wr[i]  = 1'b1;
               end
            end
         end else if (n > 1) begin
            m_err = 1'b1;
         end
         m_v = rd_req;
         if (rd_req) begin
            m_a = m_reg[ctrl_readRegA];
            m_b = m_reg[ctrl_readRegB];
         end
      end
   endtask

   task automatic cycle(input logic rst_n, input logic [3:0] oh, input logic [31:0] d,
                        input logic [1:0] a, input logic [1:0] b, input logic req,
                        input logic clr);
      ctrl_reset_n  = rst_n;
      wr_onehot     = oh;
      data_writeReg = d;
      ctrl_readRegA = a;
      ctrl_readRegB = b;
      rd_req        = req;
      clr_written   = clr;
      @(posedge clock);
      model_edge();
      #1;
      check_val("rd_a", data_readRegA, m_a);
      check_val("rd_b", data_readRegB, m_b);
      check_val("rd_valid", {31'h0, rd_valid}, {31'h0, m_v});
      check_val("written", {28'h0, written}, {28'h0, m_wr});
      check_val("wr_error", {31'h0, wr_error}, {31'h0, m_err});
   endtask

   initial begin
      logic [3:0] oh;
      int r;
      checks_cnt = 0;
      fail_cnt   = 0;
      @(negedge clock);

      // Reset then read
      cycle(1'b0, 4'h0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0);
      cycle(1'b0, 4'h0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0);
      cycle(1'b1, 4'h0, 32'h0, 2'd1, 2'd3, 1'b1, 1'b0);
      check_val("reset_valid", {31'h0, rd_valid}, 32'h1);
      check_val("reset_rd_a", data_readRegA, 32'h0);

      // Legal writes and readback
      cycle(1'b1, 4'b0100, 32'hDEADBEEF, 2'd0, 2'd0, 1'b0, 1'b0);
      cycle(1'b1, 4'b0010, 32'h12345678, 2'd0, 2'd0, 1'b0, 1'b0);
      cycle(1'b1, 4'b0000, 32'h0, 2'd2, 2'd1, 1'b1, 1'b0);
      check_val("plan_rd_a", data_readRegA, 32'hDEADBEEF);
      check_val("plan_rd_b", data_readRegB, 32'h12345678);
      check_val("plan_written", {28'h0, written}, 32'h6);

      // Same-edge forwarding
      cycle(1'b1, 4'b1000, 32'hA5A5A5A5, 2'd3, 2'd3, 1'b1, 1'b0);
      check_val("fwd_a", data_readRegA, 32'hA5A5A5A5);
      check_val("fwd_b", data_readRegB, 32'hA5A5A5A5);

      // Multi-hot write, including a same-edge read that must see the old value
      cycle(1'b1, 4'b0100, 32'h11, 2'd0, 2'd0, 1'b0, 1'b0);
      cycle(1'b1, 4'b0110, 32'hFF, 2'd2, 2'd1, 1'b1, 1'b0);
      check_val("multi_err", {31'h0, wr_error}, 32'h1);
      check_val("multi_nofwd", data_readRegA, 32'h11);
      cycle(1'b1, 4'b0000, 32'h0, 2'd2, 2'd1, 1'b1, 1'b0);
      check_val("multi_reg2", data_readRegA, 32'h11);
      check_val("multi_reg1", data_readRegB, 32'h12345678);
      check_val("multi_sticky", {31'h0, wr_error}, 32'h1);

      // Zero register
      cycle(1'b1, 4'b0001, 32'hFFFFFFFF, 2'd0, 2'd0, 1'b1, 1'b0);
      check_val("zero_rd", data_readRegA, 32'h0);
      check_val("zero_written0", {31'h0, written[0]}, 32'h0);

      // Clear/set race, then reset with a pending read and write
      cycle(1'b1, 4'b0010, 32'h77, 2'd0, 2'd0, 1'b0, 1'b1);
      check_val("clr_set", {28'h0, written}, 32'h2);
      cycle(1'b0, 4'b0100, 32'hCAFEF00D, 2'd2, 2'd2, 1'b1, 1'b0);
      check_val("rst_mid_a", data_readRegA, 32'h0);
      check_val("rst_mid_err", {31'h0, wr_error}, 32'h0);
      cycle(1'b1, 4'b0000, 32'h0, 2'd2, 2'd1, 1'b1, 1'b0);
      check_val("rst_nowrite", data_readRegA, 32'h0);

      // Randomised traffic
      for (int k = 0; k < 400; k++) begin
         r = $urandom_range(0, 9);
         if (r < 4) oh = 4'b0001 << r;
         else if (r < 7) oh = 4'b0000;
         else oh = 4'($urandom_range(0, 15));
         cycle(($urandom_range(0, 39) != 0), oh, $urandom,
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/regbank4_onehot_wr.md
Name: regbank4_onehot_wr

Overview:
- Four-entry register bank written through a one-hot write-enable vector, the direct consumer of the regfile's 2-to-4 write-address decoder output.
- Two synchronous read ports with same-edge write forwarding.
- Sticky per-register "written" status and a sticky illegal-enable error flag, for the regfile datapath and its checkers.

Parameters:
- WIDTH, 32, data width of each register and of the read/write data ports
- ZERO_REG0, 1, when 1 register 0 is hardwired to zero: writes ignored, reads return 0, written[0] never sets

Ports:
- clock  in  1  single clock, all state updates on its rising edge
- ctrl_reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clock
- wr_onehot  in  4  one-hot write enable (decoder out[3:0]); all-zero = no write
- data_writeReg  in  WIDTH  write data
- ctrl_readRegA  in  2  read port A register index
- ctrl_readRegB  in  2  read port B register index
- rd_req  in  1  read request strobe for both ports
- clr_written  in  1  clears the written[] status vector
- data_readRegA  out  WIDTH  registered read data, port A
- data_readRegB  out  WIDTH  registered read data, port B
- rd_valid  out  1  read data valid, one cycle after a sampled rd_req
- written  out  4  sticky per-register "written since reset/clear" flags
- wr_error  out  1  sticky flag: wr_onehot had more than one bit set

Behaviour:
- Reset, when ctrl_reset_n = 0 at an edge:
  - all four registers, data_readRegA/B, rd_valid, written and wr_error go to 0.
  - Reset overrides every other input on that edge, including mid-read and mid-write.
- Write, at an edge with exactly one bit i of wr_onehot set:
  - reg[i] <= data_writeReg and written[i] <= 1.
  - Exception: i = 0 with ZERO_REG0 = 1 is a no-op.
- wr_onehot = 4'b0000: no state change from the write path.
- wr_onehot with two or more bits set:
  - no register is written and written[] is unaffected by the write path.
  - wr_error <= 1, held until reset.
- clr_written at an edge: written <= 0, except the bit of a legal write in the same edge, which is set. Set wins over clear.
- Read, at an edge with rd_req = 1:
  - data_readRegA <= value of reg[ctrl_readRegA] as it stands after this edge's write, i.e. same-edge write-to-same-index is forwarded. Port B behaves the same way.
  - rd_valid <= 1. Read latency is one cycle.
- Edge with rd_req = 0: rd_valid <= 0 and data outputs hold their previous values.
- Both ports may address the same register; both return identical data.
- Illegal multi-hot write in the same edge as a read: no forwarding, the old value is returned.
- ZERO_REG0 = 1 and read index 0: output 0 regardless of forwarding.
- No combinational path from any input to any output; all outputs are flops.

Decomposition:
- Shared package regfile_pkg:
  - constants NUM_REGS = 4 and ADDR_W = 2.
  - typedef for the one-hot enable vector.
  - function onehot_legal() returning (exactly_one, multi_hot).
- One sub-module, regbank_onehot_guard:
  - classifies wr_onehot into none/legal/multi-hot.
  - produces the qualified per-register write strobes consumed by the bank.

Test Plan:
- Reset then read: hold ctrl_reset_n = 0 two edges, release, rd_req = 1 with A = 1, B = 3 -> next cycle rd_valid = 1, data_readRegA = data_readRegB = 0, written = 4'b0000, wr_error = 0.
- Legal writes and readback:
  - write 32'hDEADBEEF with wr_onehot = 4'b0100, then 32'h12345678 with 4'b0010.
  - read A = 2, B = 1 -> 32'hDEADBEEF / 32'h12345678; written = 4'b0110.
- Forwarding: in one edge wr_onehot = 4'b1000 with data 32'hA5A5A5A5, rd_req = 1, A = 3, B = 3 -> after that edge both outputs = 32'hA5A5A5A5, rd_valid = 1.
- Multi-hot:
  - reg2 = 32'h11, then an edge with wr_onehot = 4'b0110, data 32'hFF.
  - Required: wr_error = 1 and stays 1; reg1/reg2 unchanged on readback (reg2 = 32'h11); written unchanged.
- Zero register (ZERO_REG0 = 1): write 32'hFFFFFFFF with 4'b0001 and read A = 0 on the same edge -> data_readRegA = 0, written[0] = 0.
- Clear/set race and reset mid-operation:
  - clr_written = 1 with a legal write to reg1 on the same edge -> written = 4'b0010.
  - Then assert ctrl_reset_n = 0 on an edge with rd_req = 1 and a write pending -> all outputs 0, no write lands.
